// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared state type, kernel constants and line-rotation helpers
// Used by gauss_line_ptr and gauss_window_ctrl; no ports.
package gauss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    HFLUSH,
    VFLUSH,
    DONE
  } state_t;

  localparam int KSIZE   = 5;
  localparam int KHALF   = 2;
  localparam int LINE_W  = 3;
  localparam int COL_W   = 13;
  localparam int ROW_W   = 10;
  localparam int ORDER_W = KSIZE * LINE_W;

  // Next line buffer index in an n-deep rotation.
  function automatic logic [LINE_W-1:0] line_inc(input logic [LINE_W-1:0] l, input int n);
    return (int'(l) >= n - 1) ? '0 : l + 1'b1;
  endfunction

  // Window row ordering given the line holding the bottom row: the slot after
  // the bottom line is the oldest (top) row, walking forward to the bottom.
  function automatic logic [ORDER_W-1:0] order_for(input logic [LINE_W-1:0] bottom,
                                                   input int n);
    logic [ORDER_W-1:0] o;
    logic [LINE_W-1:0]  l;
    o = '0;
    l = bottom;
    for (int i = 0; i < KSIZE; i++) begin
      l = line_inc(l, n);
      o[i*LINE_W +: LINE_W] = l;
    end
    return o;
  endfunction

endpackage

// File: rtl/gauss_line_ptr.sv
// rtl/gauss_line_ptr.sv - rotating line-buffer write pointer with window row ordering
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart rotation at line 0 (frame start / frame end)
//   adv         : advance to the next line buffer (end of an input line)
//   line        : line buffer currently being written
//   order_cur   : row ordering with the current line as bottom row
//   order_prev  : row ordering with the previously written line as bottom row
module gauss_line_ptr
  import gauss_pkg::*;
#(
  parameter int NLINES = KSIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               adv,
  output logic [LINE_W-1:0]  line,
  output logic [ORDER_W-1:0] order_cur,
  output logic [ORDER_W-1:0] order_prev
);

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_prev;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      line_q <= '0;
    end else if (adv) begin
      line_q <= line_inc(line_q, NLINES);
    end
  end

  assign line_prev  = (line_q == '0) ? LINE_W'(NLINES - 1) : line_q - 1'b1;
  assign line       = line_q;
  assign order_cur  = order_for(line_q, NLINES);
  assign order_prev = order_for(line_prev, NLINES);

endmodule

// File: rtl/gauss_window_ctrl.sv
// rtl/gauss_window_ctrl.sv - 5x5 Gaussian window sequencer with horizontal/vertical flush
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en_gauss5x5              : filter enable, taken at the sof pixel accepted in IDLE
//   sof, pix_valid, pix_ready: input pixel handshake, sof marks pixel (0,0)
//   wr_line, wr_col          : line buffer and column receiving the accepted pixel
//   row_order                : 5x3b line indices, [2:0] top .. [14:12] bottom
//   filt_col, filt_row       : window centre
//   filt_valid, filt_border  : window strobe, centre within 2 of an edge
//   bypass                   : filter disabled for the current frame
//   frame_done               : pulse after the last window of a frame
module gauss_window_ctrl
  import gauss_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int NLINES = KSIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_gauss5x5,
  input  logic               sof,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [LINE_W-1:0]  wr_line,
  output logic [COL_W-1:0]   wr_col,
  output logic [ORDER_W-1:0] row_order,
  output logic [COL_W-1:0]   filt_col,
  output logic [ROW_W-1:0]   filt_row,
  output logic               filt_valid,
  output logic               filt_border,
  output logic               bypass,
  output logic               frame_done
);

  localparam logic [COL_W-1:0]   X_LAST    = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]   Y_LAST    = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]   K_COL     = COL_W'(KHALF);
  localparam logic [ROW_W-1:0]   K_ROW     = ROW_W'(KHALF);
  localparam logic [COL_W-1:0]   CX_HI     = COL_W'(WIDTH - 1 - KHALF);
  localparam logic [ROW_W-1:0]   CY_HI     = ROW_W'(HEIGHT - 1 - KHALF);
  localparam logic [COL_W-1:0]   CX_FLUSH  = COL_W'(WIDTH - KHALF);
  localparam logic [ROW_W-1:0]   CY_FLUSH  = ROW_W'(HEIGHT - KHALF);
  localparam logic [ORDER_W-1:0] ORDER_RST = order_for(LINE_W'(KSIZE - 1), KSIZE);

  state_t             state_q, state_n;
  logic [COL_W-1:0]   x_q, x_n;
  logic [ROW_W-1:0]   y_q, y_n;
  logic               hsel_q, hsel_n;
  logic               vsel_q, vsel_n;
  logic               bypass_q, bypass_n;
  logic               fv_q, fv_n;
  logic [COL_W-1:0]   fcol_q, fcol_n;
  logic [ROW_W-1:0]   frow_q, frow_n;
  logic               fborder_q, fborder_n;
  logic [ORDER_W-1:0] forder_q, forder_n;
  logic               fdone_q, fdone_n;

  logic               accept;
  logic               clear;
  logic               adv;
  logic               emit;
  logic               use_prev;
  logic [COL_W-1:0]   ecol;
  logic [ROW_W-1:0]   erow;
  logic [LINE_W-1:0]  line;
  logic [ORDER_W-1:0] order_cur;
  logic [ORDER_W-1:0] order_prev;

  gauss_line_ptr #(
    .NLINES(NLINES)
  ) u_line_ptr (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .adv       (adv),
    .line      (line),
    .order_cur (order_cur),
    .order_prev(order_prev)
  );

  assign pix_ready = (state_q == IDLE) || (state_q == RUN);
  assign accept    = pix_valid && pix_ready;

  // A sof pixel always lands at line 0, column 0, even when it aborts a frame.
  assign wr_line = sof ? '0 : line;
  assign wr_col  = sof ? '0 : x_q;

  always_comb begin
    state_n   = state_q;
    x_n       = x_q;
    y_n       = y_q;
    hsel_n    = hsel_q;
    vsel_n    = vsel_q;
    bypass_n  = bypass_q;
    fv_n      = 1'b0;
    fcol_n    = fcol_q;
    frow_n    = frow_q;
    fborder_n = fborder_q;
    forder_n  = forder_q;
    fdone_n   = 1'b0;
    clear     = 1'b0;
    adv       = 1'b0;
    emit      = 1'b0;
    use_prev  = 1'b0;
    ecol      = '0;
    erow      = '0;

    case (state_q)
      IDLE: begin
        if (accept && sof) begin
          clear    = 1'b1;
          y_n      = '0;
          bypass_n = !en_gauss5x5;
          if (en_gauss5x5) begin
            x_n     = COL_W'(1);
            state_n = RUN;
          end else begin
            x_n = '0;
          end
        end
      end

      RUN: begin
        if (accept) begin
          if (sof) begin
            // Abort: this pixel becomes (0,0) of a fresh frame.
            clear = 1'b1;
            x_n   = COL_W'(1);
            y_n   = '0;
          end else begin
            if (x_q >= K_COL && y_q >= K_ROW) begin
              emit = 1'b1;
              ecol = x_q - K_COL;
              erow = y_q - K_ROW;
            end
            if (x_q == X_LAST) begin
              x_n = '0;
              adv = 1'b1;
              // y is held through HFLUSH so the flush windows know their row.
              if (y_q >= K_ROW) begin
                hsel_n  = 1'b0;
                state_n = HFLUSH;
              end else begin
                y_n = y_q + 1'b1;
              end
            end else begin
              x_n = x_q + 1'b1;
            end
          end
        end
      end

      HFLUSH: begin
        // Line pointer has already advanced, so the finished row is the previous line.
        emit     = 1'b1;
        use_prev = 1'b1;
        ecol     = CX_FLUSH + COL_W'(hsel_q);
        erow     = y_q - K_ROW;
        if (hsel_q) begin
          hsel_n = 1'b0;
          if (y_q < Y_LAST) begin
            y_n     = y_q + 1'b1;
            state_n = RUN;
          end else begin
            x_n     = '0;
            vsel_n  = 1'b0;
            state_n = VFLUSH;
          end
        end else begin
          hsel_n = 1'b1;
        end
      end

      VFLUSH: begin
        // x doubles as the window-column counter for the two bottom rows.
        emit     = 1'b1;
        use_prev = 1'b1;
        ecol     = x_q;
        erow     = CY_FLUSH + ROW_W'(vsel_q);
        if (x_q == X_LAST) begin
          x_n = '0;
          if (vsel_q) begin
            vsel_n  = 1'b0;
            state_n = DONE;
          end else begin
            vsel_n = 1'b1;
          end
        end else begin
          x_n = x_q + 1'b1;
        end
      end

      DONE: begin
        fdone_n = 1'b1;
        clear   = 1'b1;
        x_n     = '0;
        y_n     = '0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (emit) begin
      fv_n      = 1'b1;
      fcol_n    = ecol;
      frow_n    = erow;
      forder_n  = use_prev ? order_prev : order_cur;
      fborder_n = (ecol < K_COL) || (ecol > CX_HI) || (erow < K_ROW) || (erow > CY_HI);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      hsel_q    <= 1'b0;
      vsel_q    <= 1'b0;
      bypass_q  <= 1'b1;
      fv_q      <= 1'b0;
      fcol_q    <= '0;
      frow_q    <= '0;
      fborder_q <= 1'b0;
      forder_q  <= ORDER_RST;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      x_q       <= x_n;
      y_q       <= y_n;
      hsel_q    <= hsel_n;
      vsel_q    <= vsel_n;
      bypass_q  <= bypass_n;
      fv_q      <= fv_n;
      fcol_q    <= fcol_n;
      frow_q    <= frow_n;
      fborder_q <= fborder_n;
      forder_q  <= forder_n;
      fdone_q   <= fdone_n;
    end
  end

  assign filt_valid  = fv_q;
  assign filt_col    = fcol_q;
  assign filt_row    = frow_q;
  assign filt_border = fborder_q;
  assign row_order   = forder_q;
  assign bypass      = bypass_q;
  assign frame_done  = fdone_q;

endmodule
